// File: rtl/uart_hex_cmd.sv
// rtl/uart_hex_cmd.sv - ASCII hex command parser bridging a UART byte stream to a 16-bit bus
module uart_hex_cmd #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [7:0]  rx_byte,
  output logic        rx_read,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_fifo_full,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_EOL,
    S_BUS,
    S_RESP,
    S_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    RSP_ERR,
    RSP_WOK,
    RSP_ROK
  } resp_t;

  localparam logic [7:0]  CH_CR    = 8'h0D;
  localparam logic [7:0]  CH_LF    = 8'h0A;
  localparam logic [7:0]  CH_W_UC  = 8'h57;
  localparam logic [7:0]  CH_W_LC  = 8'h77;
  localparam logic [7:0]  CH_R_UC  = 8'h52;
  localparam logic [7:0]  CH_R_LC  = 8'h72;
  localparam logic [7:0]  CH_K     = 8'h4B;
  localparam logic [7:0]  CH_QUERY = 8'h3F;
  // Last counter value at which an ack still counts; the next miss is the timeout.
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  resp_t       resp_kind;
  logic        is_write;
  logic [15:0] acc;
  logic [1:0]  digit_cnt;
  logic [15:0] tmo_cnt;
  logic [15:0] rdata_q;
  logic [2:0]  byte_idx;

  logic        consume_state;
  logic        push;
  logic [4:0]  hex_in;
  logic        hex_ok;
  logic [15:0] acc_next;
  logic [7:0]  resp_byte;
  logic [2:0]  resp_last;

  // Returns {valid, nibble} for an ASCII hex digit of either case.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      return {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      return {1'b1, c[3:0] + 4'd9};
    end else begin
      return 5'b0_0000;
    end
  endfunction

  // Uppercase ASCII for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign hex_in   = hex_decode(rx_byte);
  assign hex_ok   = hex_in[4];
  assign acc_next = {acc[11:0], hex_in[3:0]};

  // The pop strobe must coincide with the sampled byte so the FIFO head advances
  // before the next decision; it is therefore decoded, never registered.
  assign consume_state = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA) ||
                         (state == S_EOL)  || (state == S_FLUSH);
  assign rx_read       = ~rst & rx_ready & consume_state;

  // A response byte goes out in every RESP cycle the TX FIFO has room.
  assign push     = ~rst & (state == S_RESP) & ~tx_fifo_full;
  assign tx_start = push;
  assign tx_data  = push ? resp_byte : 8'h00;

  // Selects the response byte addressed by byte_idx and the index of the final LF.
  always_comb begin
    resp_byte = 8'h00;
    resp_last = 3'd2;
    case (resp_kind)
      RSP_ROK: begin
        resp_last = 3'd5;
        case (byte_idx)
          3'd0:    resp_byte = hex_ascii(rdata_q[15:12]);
          3'd1:    resp_byte = hex_ascii(rdata_q[11:8]);
          3'd2:    resp_byte = hex_ascii(rdata_q[7:4]);
          3'd3:    resp_byte = hex_ascii(rdata_q[3:0]);
          3'd4:    resp_byte = CH_CR;
          default: resp_byte = CH_LF;
        endcase
      end
      RSP_WOK: begin
        case (byte_idx)
          3'd0:    resp_byte = CH_K;
          3'd1:    resp_byte = CH_CR;
          default: resp_byte = CH_LF;
        endcase
      end
      default: begin
        case (byte_idx)
          3'd0:    resp_byte = CH_QUERY;
          3'd1:    resp_byte = CH_CR;
          default: resp_byte = CH_LF;
        endcase
      end
    endcase
  end

  // Command FSM: parsing, bus handshake with timeout, and response sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      resp_kind <= RSP_ERR;
      is_write  <= 1'b0;
      acc       <= 16'h0000;
      digit_cnt <= 2'd0;
      tmo_cnt   <= 16'h0000;
      rdata_q   <= 16'h0000;
      byte_idx  <= 3'd0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 16'h0000;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_ready) begin
            if (rx_byte == CH_W_UC || rx_byte == CH_W_LC) begin
              is_write  <= 1'b1;
              acc       <= 16'h0000;
              digit_cnt <= 2'd0;
              state     <= S_ADDR;
            end else if (rx_byte == CH_R_UC || rx_byte == CH_R_LC) begin
              is_write  <= 1'b0;
              acc       <= 16'h0000;
              digit_cnt <= 2'd0;
              state     <= S_ADDR;
            end else if (rx_byte != CH_CR && rx_byte != CH_LF) begin
              state <= S_FLUSH;
            end
          end
        end

        S_ADDR: begin
          if (rx_ready) begin
            if (hex_ok) begin
              acc       <= acc_next;
              digit_cnt <= digit_cnt + 2'd1;
              if (digit_cnt == 2'd3) begin
                bus_addr <= acc_next;
                if (is_write) begin
                  acc   <= 16'h0000;
                  state <= S_DATA;
                end else begin
                  state <= S_EOL;
                end
              end
            end else if (rx_byte == CH_CR) begin
              resp_kind <= RSP_ERR;
              byte_idx  <= 3'd0;
              state     <= S_RESP;
            end else begin
              state <= S_FLUSH;
            end
          end
        end

        S_DATA: begin
          if (rx_ready) begin
            if (hex_ok) begin
              acc       <= acc_next;
              digit_cnt <= digit_cnt + 2'd1;
              if (digit_cnt == 2'd3) begin
                bus_wdata <= acc_next;
                state     <= S_EOL;
              end
            end else if (rx_byte == CH_CR) begin
              resp_kind <= RSP_ERR;
              byte_idx  <= 3'd0;
              state     <= S_RESP;
            end else begin
              state <= S_FLUSH;
            end
          end
        end

        S_EOL: begin
          if (rx_ready) begin
            if (rx_byte == CH_CR) begin
              bus_we  <= is_write;
              bus_re  <= ~is_write;
              tmo_cnt <= 16'h0000;
              state   <= S_BUS;
            end else begin
              state <= S_FLUSH;
            end
          end
        end

        S_BUS: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (bus_ack) begin
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            byte_idx  <= 3'd0;
            state     <= S_RESP;
            if (is_write) begin
              resp_kind <= RSP_WOK;
            end else begin
              resp_kind <= RSP_ROK;
              rdata_q   <= bus_rdata;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            tmo_cnt   <= tmo_cnt + 16'd1;
            resp_kind <= RSP_ERR;
            byte_idx  <= 3'd0;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        S_RESP: begin
          if (!tx_fifo_full) begin
            if (byte_idx == resp_last) begin
              byte_idx <= 3'd0;
              state    <= S_IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end

        S_FLUSH: begin
          if (rx_ready && rx_byte == CH_CR) begin
            resp_kind <= RSP_ERR;
            byte_idx  <= 3'd0;
            state     <= S_RESP;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
